// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame receiver.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_SYNC_LOW = 1;

  localparam int COLOR_W = 8;
  localparam int PX_W    = 10;
  localparam int LN_W    = 9;
  localparam int SUM_W   = 16;

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } vga_state_e;

endpackage

// File: rtl/vga_edge_detect.sv
// Strobe-qualified sample register and assert-edge detector for one sync line.
module vga_edge_detect #(
  parameter int SYNC_LOW = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pix_en_i,
  input  logic sync_i,
  output logic edge_o
);

  logic norm;
  logic cur_q;
  logic prev_q;

  // Normalised so that 1 always means "sync asserted".
  assign norm = (SYNC_LOW != 0) ? ~sync_i : sync_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else if (pix_en_i) begin
      prev_q <= cur_q;
      cur_q  <= norm;
    end
  end

  assign edge_o = cur_q & ~prev_q;

endmodule

// File: rtl/vga_frame_receiver.sv
// Locks to VGA frame timing, checks line/frame geometry, sums active pixels
// per frame and captures one selectable pixel.
module vga_frame_receiver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int SYNC_LOW = VGA_SYNC_LOW
) (
  input  logic               ext_clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [COLOR_W-1:0] color,
  input  logic               HSync,
  input  logic               VSync,
  input  logic               on,
  input  logic [PX_W-1:0]    cap_x,
  input  logic [LN_W-1:0]    cap_y,
  output logic               locked,
  output logic               frame_done,
  output logic [SUM_W-1:0]   checksum,
  output logic [COLOR_W-1:0] cap_pixel,
  output logic               h_err,
  output logic               v_err
);

  localparam logic [PX_W-1:0] H_ACT_C = PX_W'(H_ACTIVE);
  localparam logic [LN_W-1:0] V_ACT_C = LN_W'(V_ACTIVE);

  logic               hs_edge;
  logic               vs_edge;
  logic [COLOR_W-1:0] color_q;
  logic               on_q;
  logic               vld_q;

  vga_state_e         state_q,      state_d;
  logic [PX_W-1:0]    px_q,         px_d;
  logic [LN_W-1:0]    ln_q,         ln_d;
  logic [SUM_W-1:0]   sum_q,        sum_d;
  logic [COLOR_W-1:0] shadow_q,     shadow_d;
  logic [SUM_W-1:0]   checksum_q,   checksum_d;
  logic [COLOR_W-1:0] cap_pixel_q,  cap_pixel_d;
  logic               frame_done_q, frame_done_d;
  logic               h_err_q,      h_err_d;
  logic               v_err_q,      v_err_d;

  logic [PX_W-1:0]    px_a;
  logic [LN_W-1:0]    ln_b;
  logic [SUM_W-1:0]   sum_a;
  logic [COLOR_W-1:0] shadow_a;
  logic               cap_hit;

  vga_edge_detect #(.SYNC_LOW(SYNC_LOW)) u_hs_edge (
    .clk_i    (ext_clk),
    .reset_i  (reset),
    .pix_en_i (pix_en),
    .sync_i   (HSync),
    .edge_o   (hs_edge)
  );

  vga_edge_detect #(.SYNC_LOW(SYNC_LOW)) u_vs_edge (
    .clk_i    (ext_clk),
    .reset_i  (reset),
    .pix_en_i (pix_en),
    .sync_i   (VSync),
    .edge_o   (vs_edge)
  );

  // vld_q marks the one cycle in which a freshly registered sample is processed.
  always_ff @(posedge ext_clk) begin
    if (reset) begin
      color_q <= '0;
      on_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= pix_en;
      if (pix_en) begin
        color_q <= color;
        on_q    <= on;
      end
    end
  end

  assign cap_hit = (px_q == cap_x) && (ln_q == cap_y) &&
                   (px_q < H_ACT_C) && (ln_q < V_ACT_C);

  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    ln_d         = ln_q;
    sum_d        = sum_q;
    shadow_d     = shadow_q;
    checksum_d   = checksum_q;
    cap_pixel_d  = cap_pixel_q;
    frame_done_d = 1'b0;
    h_err_d      = h_err_q;
    v_err_d      = v_err_q;
    px_a         = px_q;
    ln_b         = ln_q;
    sum_a        = sum_q;
    shadow_a     = shadow_q;

    if (vld_q) begin
      unique case (state_q)
        HUNT: begin
          if (vs_edge) begin
            state_d  = FRAME;
            px_d     = '0;
            ln_d     = '0;
            sum_d    = '0;
            shadow_d = '0;
          end
        end
        FRAME: begin
          if (on_q) begin
            px_a  = (&px_q) ? px_q : px_q + 1'b1;
            sum_a = sum_q + SUM_W'(color_q);
            if (cap_hit) shadow_a = color_q;
          end
          // A VSync edge also closes the open line, before the frame closes.
          if (hs_edge || vs_edge) begin
            if (px_a != '0) begin
              if (px_a != H_ACT_C) h_err_d = 1'b1;
              ln_b = (&ln_q) ? ln_q : ln_q + 1'b1;
            end
            px_a = '0;
          end
          px_d     = px_a;
          ln_d     = ln_b;
          sum_d    = sum_a;
          shadow_d = shadow_a;
          if (vs_edge) begin
            if (ln_b != V_ACT_C) v_err_d = 1'b1;
            checksum_d   = sum_a;
            cap_pixel_d  = shadow_a;
            frame_done_d = 1'b1;
            px_d         = '0;
            ln_d         = '0;
            sum_d        = '0;
            shadow_d     = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      state_q      <= HUNT;
      px_q         <= '0;
      ln_q         <= '0;
      sum_q        <= '0;
      shadow_q     <= '0;
      checksum_q   <= '0;
      cap_pixel_q  <= '0;
      frame_done_q <= 1'b0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      ln_q         <= ln_d;
      sum_q        <= sum_d;
      shadow_q     <= shadow_d;
      checksum_q   <= checksum_d;
      cap_pixel_q  <= cap_pixel_d;
      frame_done_q <= frame_done_d;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
    end
  end

  assign locked     = (state_q == FRAME);
  assign frame_done = frame_done_q;
  assign checksum   = checksum_q;
  assign cap_pixel  = cap_pixel_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Directed bench for vga_frame_receiver with a 4x3 active area.
module tb_vga_frame_receiver;

  logic        ext_clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [7:0]  color;
  logic        HSync;
  logic        VSync;
  logic        on;
  logic [9:0]  cap_x;
  logic [8:0]  cap_y;
  logic        locked;
  logic        frame_done;
  logic [15:0] checksum;
  logic [7:0]  cap_pixel;
  logic        h_err;
  logic        v_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit strobe    = 1'b0;

  always #5 ext_clk = ~ext_clk;

  vga_frame_receiver #(.H_ACTIVE(4), .V_ACTIVE(3), .SYNC_LOW(1)) dut (
    .ext_clk    (ext_clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .color      (color),
    .HSync      (HSync),
    .VSync      (VSync),
    .on         (on),
    .cap_x      (cap_x),
    .cap_y      (cap_y),
    .locked     (locked),
    .frame_done (frame_done),
    .checksum   (checksum),
    .cap_pixel  (cap_pixel),
    .h_err      (h_err),
    .v_err      (v_err)
  );

  // One strobed sample; in strobe mode it is followed by a pix_en=0 cycle of junk.
  task automatic samp(input logic [7:0] c, input logic o, input logic h, input logic v);
    color = c; on = o; HSync = h; VSync = v; pix_en = 1'b1;
    @(posedge ext_clk); #1;
    if (strobe) begin
      pix_en = 1'b0; color = 8'hAA; on = 1'b1; HSync = 1'b0; VSync = 1'b0;
      @(posedge ext_clk); #1;
    end
  endtask

  task automatic line(input int row, input int npx, input bit ff);
    samp(8'h00, 1'b0, 1'b0, 1'b1);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    for (int col = 0; col < npx; col++)
      samp(ff ? 8'hFF : 8'(row * 4 + col + 1), 1'b1, 1'b1, 1'b1);
  endtask

  task automatic body(input int nlines, input bit ff);
    for (int r = 0; r < nlines; r++) line(r, 4, ff);
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b1; color = '0; on = 1'b0; HSync = 1'b1; VSync = 1'b1;
    cap_x = 10'd2; cap_y = 9'd1;
    repeat (3) @(posedge ext_clk);
    #1;
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked);
    else pass_cnt++;
    total_cnt++;
    if ({frame_done, checksum, cap_pixel, h_err, v_err} !== 27'd0)
      $display("FAIL reset_outputs: fd=%b cs=%h cap=%h he=%b ve=%b want all 0",
               frame_done, checksum, cap_pixel, h_err, v_err);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_lock();
    body(3, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL lock_early: locked=%b want 0", locked);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (locked !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL lock_set: locked=%b fd=%b want 1 0", locked, frame_done);
    else pass_cnt++;
    body(3, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL lock_fd_early: fd=%b want 0", frame_done);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL lock_fd: fd=%b want 1", frame_done);
    else pass_cnt++;
    total_cnt++;
    if (checksum !== 16'd78) $display("FAIL lock_checksum: got %0d want 78", checksum);
    else pass_cnt++;
    total_cnt++;
    if (cap_pixel !== 8'd7) $display("FAIL capture_2_1: got %0d want 7", cap_pixel);
    else pass_cnt++;
    total_cnt++;
    if (h_err !== 1'b0 || v_err !== 1'b0)
      $display("FAIL lock_errs: h_err=%b v_err=%b want 0 0", h_err, v_err);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL fd_one_cycle: fd=%b want 0", frame_done);
    else pass_cnt++;
  endtask

  task automatic test_checksum_ff();
    body(3, 1'b1);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b1 || checksum !== 16'h0BF4)
      $display("FAIL checksum_ff: fd=%b cs=%h want 1 0bf4", frame_done, checksum);
    else pass_cnt++;
    total_cnt++;
    if (cap_pixel !== 8'hFF) $display("FAIL capture_ff: got %h want ff", cap_pixel);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_capture_outside();
    cap_x = 10'd9;
    body(3, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (cap_pixel !== 8'd0 || checksum !== 16'd78)
      $display("FAIL capture_outside: cap=%0d cs=%0d want 0 78", cap_pixel, checksum);
    else pass_cnt++;
    cap_x = 10'd2;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_strobe();
    strobe = 1'b1;
    body(3, 1'b0);
    color = 8'h00; on = 1'b0; HSync = 1'b1; VSync = 1'b0; pix_en = 1'b1;
    @(posedge ext_clk); #1;
    pix_en = 1'b0; color = 8'hAA; on = 1'b1; HSync = 1'b0; VSync = 1'b0;
    @(posedge ext_clk); #1;
    total_cnt++;
    if (frame_done !== 1'b1 || checksum !== 16'd78 || cap_pixel !== 8'd7)
      $display("FAIL strobe_frame: fd=%b cs=%0d cap=%0d want 1 78 7",
               frame_done, checksum, cap_pixel);
    else pass_cnt++;
    @(posedge ext_clk); #1;
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL strobe_fd_pulse: fd=%b want 0", frame_done);
    else pass_cnt++;
    strobe = 1'b0;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_coincide();
    body(3, 1'b0);
    samp(8'h00, 1'b0, 1'b0, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b1 || v_err !== 1'b0 || h_err !== 1'b0 || checksum !== 16'd78)
      $display("FAIL coincide: fd=%b ve=%b he=%b cs=%0d want 1 0 0 78",
               frame_done, v_err, h_err, checksum);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_errors();
    line(0, 4, 1'b0);
    line(1, 5, 1'b0);
    samp(8'h00, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (h_err !== 1'b0) $display("FAIL h_err_early: got %b want 0", h_err);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (h_err !== 1'b1) $display("FAIL h_err_rise: got %b want 1", h_err);
    else pass_cnt++;
    for (int col = 0; col < 4; col++) samp(8'(9 + col), 1'b1, 1'b1, 1'b1);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b1 || v_err !== 1'b0 || checksum !== 16'd87)
      $display("FAIL long_line_frame: fd=%b ve=%b cs=%0d want 1 0 87",
               frame_done, v_err, checksum);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);

    body(2, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (v_err !== 1'b0) $display("FAIL v_err_early: got %b want 0", v_err);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b1 || v_err !== 1'b1 || checksum !== 16'd36)
      $display("FAIL short_frame: fd=%b ve=%b cs=%0d want 1 1 36",
               frame_done, v_err, checksum);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);

    body(3, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b1 || h_err !== 1'b1 || v_err !== 1'b1)
      $display("FAIL errs_sticky: fd=%b he=%b ve=%b want 1 1 1", frame_done, h_err, v_err);
    else pass_cnt++;
    samp(8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    line(0, 4, 1'b0);
    samp(8'h00, 1'b0, 1'b0, 1'b1);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    samp(8'd5, 1'b1, 1'b1, 1'b1);
    samp(8'd6, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge ext_clk);
    #1;
    total_cnt++;
    if ({locked, frame_done, checksum, cap_pixel, h_err, v_err} !== 28'd0)
      $display("FAIL reset_mid: lk=%b fd=%b cs=%h cap=%h he=%b ve=%b want all 0",
               locked, frame_done, checksum, cap_pixel, h_err, v_err);
    else pass_cnt++;
    reset = 1'b0;
    body(3, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (locked !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL relock: locked=%b fd=%b want 1 0", locked, frame_done);
    else pass_cnt++;
    body(3, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b0);
    samp(8'h00, 1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (frame_done !== 1'b1 || checksum !== 16'd78 || h_err !== 1'b0 || v_err !== 1'b0)
      $display("FAIL recover_frame: fd=%b cs=%0d he=%b ve=%b want 1 78 0 0",
               frame_done, checksum, h_err, v_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_checksum_ff();
    test_capture_outside();
    test_strobe();
    test_coincide();
    test_errors();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
